// File: rtl/d5m_pixel_source.sv
// TRDB-D5M sensor-side stream generator: FrameValid/LineValid/PixelData exactly as the sensor drives
// them, one pixel per clock, with selectable test patterns and a completed-frame counter.
module d5m_pixel_source #(
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int H_BLANK_CC  = 16,
    parameter int FV_LEAD_CC  = 4,
    parameter int FV_TRAIL_CC = 4,
    parameter int V_BLANK_CC  = 64
) (
    input  logic        ul1Clock,
    input  logic        ul1Reset_n,
    input  logic        ul1Enable,
    input  logic [1:0]  ul2Pattern,
    input  logic [11:0] ul12ConstData,
    output logic        ul1FrameValid,
    output logic        ul1LineValid,
    output logic [11:0] ul12PixelData,
    output logic [15:0] ul16FrameCount,
    output logic        ul1FrameDone
);
    localparam int CW   = (ACTIVE_COLS > 1) ? $clog2(ACTIVE_COLS) : 1;
    localparam int RW   = (ACTIVE_ROWS > 1) ? $clog2(ACTIVE_ROWS) : 1;
    localparam int TMAX = (H_BLANK_CC > V_BLANK_CC ? H_BLANK_CC : V_BLANK_CC) >
                          (FV_LEAD_CC > FV_TRAIL_CC ? FV_LEAD_CC : FV_TRAIL_CC) ?
                          (H_BLANK_CC > V_BLANK_CC ? H_BLANK_CC : V_BLANK_CC) :
                          (FV_LEAD_CC > FV_TRAIL_CC ? FV_LEAD_CC : FV_TRAIL_CC);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(ACTIVE_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ACTIVE_ROWS - 1);
    localparam logic [TW-1:0] LEAD_LAST  = TW'(FV_LEAD_CC - 1);
    localparam logic [TW-1:0] HBL_LAST   = TW'(H_BLANK_CC - 1);
    localparam logic [TW-1:0] TRAIL_LAST = TW'(FV_TRAIL_CC - 1);
    localparam logic [TW-1:0] VBL_LAST   = TW'(V_BLANK_CC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FV_LEAD, S_ACTIVE, S_HBLANK, S_FV_TRAIL, S_VBLANK
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [TW-1:0] r_tmr;
    logic [1:0]    r_pat;
    logic [11:0]   r_const;
    logic          r_fv;
    logic          r_lv;
    logic [11:0]   r_data;
    logic [15:0]   r_count;
    logic          r_done;

    logic [11:0]   w_pix_first;
    logic [11:0]   w_pix_next_col;
    logic [11:0]   w_pix_next_row;

    function automatic logic [11:0] f_pixel(input logic [1:0] pat, input logic [11:0] cst,
                                            input logic [5:0] row6, input logic [11:0] col12,
                                            input logic [11:0] cnt12);
        case (pat)
            2'd0:    return col12;
            2'd1:    return {row6, col12[5:0]};
            2'd2:    return cst;
            default: return cnt12 + col12;
        endcase
    endfunction

    // Data is registered alongside LV, so each transition loads the pixel the new position will show.
    assign w_pix_first    = f_pixel(r_pat, r_const, 6'd0, 12'd0, r_count[11:0]);
    assign w_pix_next_col = f_pixel(r_pat, r_const, 6'(r_row), 12'(r_col + CW'(1)), r_count[11:0]);
    assign w_pix_next_row = f_pixel(r_pat, r_const, 6'(r_row + RW'(1)), 12'd0, r_count[11:0]);

    always_ff @(posedge ul1Clock) begin
        if (!ul1Reset_n) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_tmr   <= '0;
            r_pat   <= '0;
            r_const <= '0;
            r_fv    <= 1'b0;
            r_lv    <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ul1Enable) begin
                        r_state <= S_FV_LEAD;
                        r_fv    <= 1'b1;
                        r_tmr   <= '0;
                        r_pat   <= ul2Pattern;
                        r_const <= ul12ConstData;
                    end
                end
                S_FV_LEAD: begin
                    if (r_tmr == LEAD_LAST) begin
                        r_state <= S_ACTIVE;
                        r_lv    <= 1'b1;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_data  <= w_pix_first;
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                S_ACTIVE: begin
                    if (r_col == COL_LAST) begin
                        r_lv    <= 1'b0;
                        r_data  <= '0;
                        r_tmr   <= '0;
                        r_state <= (r_row == ROW_LAST) ? S_FV_TRAIL : S_HBLANK;
                    end else begin
                        r_col  <= r_col + CW'(1);
                        r_data <= w_pix_next_col;
                    end
                end
                S_HBLANK: begin
                    if (r_tmr == HBL_LAST) begin
                        r_state <= S_ACTIVE;
                        r_lv    <= 1'b1;
                        r_row   <= r_row + RW'(1);
                        r_col   <= '0;
                        r_data  <= w_pix_next_row;
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                S_FV_TRAIL: begin
                    if (r_tmr == TRAIL_LAST) begin
                        r_state <= S_VBLANK;
                        r_fv    <= 1'b0;
                        r_done  <= 1'b1;
                        r_count <= r_count + 16'd1;
                        r_tmr   <= '0;
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                S_VBLANK: begin
                    // Enable only matters here and in IDLE, so a dropped enable never cuts a frame short.
                    if (r_tmr == VBL_LAST) begin
                        if (ul1Enable) begin
                            r_state <= S_FV_LEAD;
                            r_fv    <= 1'b1;
                            r_tmr   <= '0;
                            r_pat   <= ul2Pattern;
                            r_const <= ul12ConstData;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ul1FrameValid  = r_fv;
    assign ul1LineValid   = r_lv;
    assign ul12PixelData  = r_data;
    assign ul16FrameCount = r_count;
    assign ul1FrameDone   = r_done;
endmodule

// File: tb/tb_d5m_pixel_source.sv
// Bench for d5m_pixel_source: frame-level model compares every output every cycle on a small frame,
// plus a second tiny-frame instance run up to frame count 4095 for the pattern-3 wrap.
module tb_d5m_pixel_source;
    localparam int L = 1, C = 4, R = 3, H = 2, T = 1, V = 3;
    localparam int ACT = R * C + (R - 1) * H;
    localparam int PER = L + ACT + T + V;
    localparam int PER_B = 1 + 4 + 1 + 1;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [1:0]  pat;
    logic [11:0] cst;
    logic        fv, lv, done;
    logic [11:0] data;
    logic [15:0] count;

    logic        rst_b, en_b;
    logic        fvb, lvb, doneb;
    logic [11:0] datab;
    logic [15:0] countb;

    int checks = 0;
    int failures = 0;
    int mcount = 0;
    int fidx = 0;

    always #5 clk = ~clk;

    d5m_pixel_source #(.ACTIVE_COLS(C), .ACTIVE_ROWS(R), .H_BLANK_CC(H), .FV_LEAD_CC(L),
                       .FV_TRAIL_CC(T), .V_BLANK_CC(V)) dut (
        .ul1Clock(clk), .ul1Reset_n(rst_n), .ul1Enable(en), .ul2Pattern(pat),
        .ul12ConstData(cst), .ul1FrameValid(fv), .ul1LineValid(lv), .ul12PixelData(data),
        .ul16FrameCount(count), .ul1FrameDone(done));

    d5m_pixel_source #(.ACTIVE_COLS(4), .ACTIVE_ROWS(1), .H_BLANK_CC(1), .FV_LEAD_CC(1),
                       .FV_TRAIL_CC(1), .V_BLANK_CC(1)) dut_b (
        .ul1Clock(clk), .ul1Reset_n(rst_b), .ul1Enable(en_b), .ul2Pattern(2'd3),
        .ul12ConstData(12'h000), .ul1FrameValid(fvb), .ul1LineValid(lvb), .ul12PixelData(datab),
        .ul16FrameCount(countb), .ul1FrameDone(doneb));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] mpix(input int p, input logic [11:0] c, input int row,
                                         input int col, input int cnt);
        case (p)
            0:       return 12'(col);
            1:       return 12'((row % 64) * 64 + (col % 64));
            2:       return c;
            default: return 12'((cnt + col) % 4096);
        endcase
    endfunction

    // Expected outputs k cycles after FV rises, from the frame timeline arithmetic.
    task automatic exp_at(input int k, input int p, input logic [11:0] c, input int cnt,
                          output logic efv, output logic elv, output logic [11:0] ed,
                          output logic edn, output int ecnt);
        efv = 1'b0; elv = 1'b0; ed = '0; edn = 1'b0; ecnt = cnt;
        if (k < L) begin
            efv = 1'b1;
        end else if (k < L + ACT) begin
            int j, line, pos;
            j = k - L; line = j / (C + H); pos = j % (C + H);
            efv = 1'b1;
            if (pos < C) begin
                elv = 1'b1;
                ed  = mpix(p, c, line, pos, cnt);
            end
        end else if (k < L + ACT + T) begin
            efv = 1'b1;
        end else begin
            edn  = (k == L + ACT + T);
            ecnt = (cnt + 1) % 65536;
        end
    endtask

    task automatic run_frame(input int p, input logic [11:0] c, input int drop_at, input int reen_at);
        logic efv, elv, edn;
        logic [11:0] ed;
        int ecnt;
        en = 1'b1; pat = 2'(p); cst = c;
        for (int k = 0; k < PER; k++) begin
            @(posedge clk); @(negedge clk);
            exp_at(k, p, c, mcount, efv, elv, ed, edn, ecnt);
            chk($sformatf("fv f%0d k%0d", fidx, k), 32'(fv), 32'(efv));
            chk($sformatf("lv f%0d k%0d", fidx, k), 32'(lv), 32'(elv));
            chk($sformatf("data f%0d k%0d", fidx, k), 32'(data), 32'(ed));
            chk($sformatf("done f%0d k%0d", fidx, k), 32'(done), 32'(edn));
            chk($sformatf("count f%0d k%0d", fidx, k), 32'(count), 32'(ecnt));
            if (k == 3) begin
                pat = 2'(p) ^ 2'd2;
                cst = 12'($urandom);
            end
            if (k == drop_at) en = 1'b0;
            if (k == reen_at) en = 1'b1;
        end
        mcount = (mcount + 1) % 65536;
        fidx++;
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("%s fv %0d", tag, i), 32'(fv), 32'd0);
            chk($sformatf("%s lv %0d", tag, i), 32'(lv), 32'd0);
            chk($sformatf("%s data %0d", tag, i), 32'(data), 32'd0);
            chk($sformatf("%s done %0d", tag, i), 32'(done), 32'd0);
            chk($sformatf("%s count %0d", tag, i), 32'(count), 32'(mcount));
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; pat = 2'd0; cst = 12'd0;
        rst_b = 1'b0; en_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst fv", 32'(fv), 32'd0);
        chk("rst lv", 32'(lv), 32'd0);
        chk("rst data", 32'(data), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst count", 32'(count), 32'd0);
        rst_n = 1'b1;

        // Ramp frames back to back, then row/col and constant patterns.
        repeat (3) run_frame(0, 12'h000, -1, -1);
        run_frame(1, 12'($urandom), -1, -1);
        run_frame(2, 12'hABC, -1, -1);
        for (int i = 0; i < 6; i++) run_frame(int'($urandom_range(0, 3)), 12'($urandom), -1, -1);

        // Enable dropped in line 1: frame completes, then IDLE until re-enabled.
        run_frame(0, 12'h000, 4, -1);
        idle_check(6, "idle");
        run_frame(3, 12'($urandom), -1, -1);
        // Enable dropped mid-frame, restored inside VBLANK: no extra gap.
        run_frame(1, 12'($urandom), 4, L + ACT + T);
        run_frame(2, 12'($urandom), -1, -1);

        // Reset while col 2 is on the wire.
        en = 1'b1; pat = 2'd0; cst = 12'd0;
        @(posedge clk); @(negedge clk);
        chk("mr lead fv", 32'(fv), 32'd1);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("mr col2 data", 32'(data), 32'd2);
        chk("mr col2 lv", 32'(lv), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mr fv", 32'(fv), 32'd0);
        chk("mr lv", 32'(lv), 32'd0);
        chk("mr data", 32'(data), 32'd0);
        chk("mr done", 32'(done), 32'd0);
        chk("mr count", 32'(count), 32'd0);
        rst_n = 1'b1;
        mcount = 0;
        run_frame(0, 12'h000, -1, -1);

        // Tiny-frame instance: frame f has FV rising on edge 1 + f*PER_B after release.
        en = 1'b0;
        rst_b = 1'b1; en_b = 1'b1;
        repeat (1 + 4095 * PER_B - 1) @(posedge clk);
        @(posedge clk); @(negedge clk);
        chk("b lead fv", 32'(fvb), 32'd1);
        chk("b lead lv", 32'(lvb), 32'd0);
        chk("b lead count", 32'(countb), 32'd4095);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("b lv %0d", i), 32'(lvb), 32'd1);
            chk($sformatf("b data %0d", i), 32'(datab), 32'(mpix(3, 12'h000, 0, i, 4095)));
        end
        @(posedge clk); @(negedge clk);
        chk("b trail fv", 32'(fvb), 32'd1);
        chk("b trail lv", 32'(lvb), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("b vb fv", 32'(fvb), 32'd0);
        chk("b vb done", 32'(doneb), 32'd1);
        chk("b vb count", 32'(countb), 32'd4096);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
